pulse_burst_gen: RTL and testbench
==================================

Name: pulse_burst_gen

Overview:
- Transmitter side of the programmable counter's count-pulse interface.
- Generates a programmed burst of N count pulses with programmable high/low widths on pulse_out, for the counter's count-clock input.
- Drives the companion enable, up_down, load and load_data signals so a counter can be preloaded and then stepped.
- Sits beside the counter in the top level; sequenced by host pins through a single start/abort handshake.

Parameters:
WIDTH, 8, width of burst count, preload value and pulses_sent
LEN_W, 4, width of the high_len / low_len phase-length fields

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle request; sampled only in IDLE
abort  input  1  cancel burst; honoured in any busy state
burst_len  input  WIDTH  number of pulses to emit (0 allowed)
high_len  input  LEN_W  pulse high width in clk cycles (0 treated as 1)
low_len  input  LEN_W  pulse low width in clk cycles (0 treated as 1)
dir  input  1  direction for the burst, 1=up
preload_en  input  1  issue a load cycle before the burst
preload_val  input  WIDTH  value presented with load
pulse_out  output  1  count pulse to counter
enable  output  1  counter enable
up_down  output  1  latched dir
load  output  1  one-cycle load strobe
load_data  output  WIDTH  preload value, valid while load=1
busy  output  1  high in any state except IDLE
done  output  1  one-cycle completion strobe
aborted  output  1  one-cycle abort strobe
pulses_sent  output  WIDTH  pulses emitted in current/last burst

Behaviour:
- Reset (async, rst=1): state=IDLE; every output 0; all latched fields 0.
- States: IDLE, LOAD, HIGH, LOW, FIN. All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.
- IDLE + start=1 at edge k:
  - Latch burst_len, high_len, low_len, dir, preload_en, preload_val.
  - Clear pulses_sent.
  - Next state is LOAD if preload_en=1, else HIGH if burst_len!=0, else FIN.
  - start is ignored outside IDLE.
- LOAD: exactly one cycle. load=1, load_data=latched preload_val. Then HIGH if remaining!=0, else FIN.
- HIGH:
  - pulse_out=1, enable=1.
  - Lasts max(high_len,1) cycles via the phase counter.
  - On leaving HIGH: remaining decrements and pulses_sent increments (saturating at all-ones).
  - Then go to LOW.
- LOW:
  - pulse_out=0, enable=1.
  - Lasts max(low_len,1) cycles.
  - Then HIGH if remaining!=0, else FIN.
  - The final pulse's LOW phase is always completed.
- FIN: one cycle, done=1. Then IDLE.
- up_down equals latched dir whenever busy=1, and holds its value after return to IDLE.
- Pulse period = max(high_len,1)+max(low_len,1) cycles. Pulses are back-to-back with no gap cycles.
- abort=1 in LOAD/HIGH/LOW:
  - Next state is IDLE.
  - pulse_out, enable and load drop at that edge.
  - aborted=1 for one cycle; done is not asserted.
  - pulses_sent keeps its count; a HIGH phase cut short is not counted.
- abort in IDLE or FIN: no effect; FIN still emits done.
- abort and start together in IDLE: start wins, abort ignored.
- burst_len=0 with preload_en=1: LOAD then FIN; no pulses emitted.
- Reset mid-burst: immediate return to IDLE with all outputs 0; no done, no aborted.
- Maximum burst: burst_len=2^WIDTH-1. Remaining and phase counters must not wrap.

Test Plan:
- Basic burst: burst_len=3, high_len=2, low_len=1, dir=1, preload_en=0, start at edge 0.
  - pulse_out=1 in cycles 1-2, 4-5, 7-8 and 0 in cycles 3, 6, 9.
  - done=1 in cycle 10; busy=0 from cycle 11; pulses_sent=3; up_down=1 throughout.
- Preload: preload_en=1, preload_val=0xA5, burst_len=1, high_len=0, low_len=0, dir=0.
  - load=1 with load_data=0xA5 in cycle 1.
  - pulse_out=1 in cycle 2 and 0 in cycle 3.
  - done in cycle 4; up_down=0.
- Zero length: burst_len=0, preload_en=0 -> FIN in cycle 1 with done=1; pulse_out never asserted; pulses_sent=0.
- Abort: burst_len=10, high_len=1, low_len=1; assert abort in the 3rd HIGH cycle.
  - pulse_out=0 next cycle; aborted=1 for one cycle; done never asserted; pulses_sent=2.
  - A new start is then accepted.
- Start while busy: pulse start mid-burst with different burst_len -> ignored; original count completes.
- Async reset mid-LOW: assert rst between edges.
  - All outputs 0 immediately, without a clock edge.
  - After deassert, state is IDLE; no done or aborted pulse is produced.

Source files
------------

// File: rtl/pulse_burst_gen.sv
// pulse_burst_gen: transmitter side of a counter's count-pulse interface.
// Emits a programmed burst of count pulses with programmable high/low widths,
// and drives the counter's enable, up_down and load/load_data companions.
// Host control is a single start/abort handshake. All outputs come from flops.
module pulse_burst_gen #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] burst_len,
  input  logic [LEN_W-1:0] high_len,
  input  logic [LEN_W-1:0] low_len,
  input  logic             dir,
  input  logic             preload_en,
  input  logic [WIDTH-1:0] preload_val,
  output logic             pulse_out,
  output logic             enable,
  output logic             up_down,
  output logic             load,
  output logic [WIDTH-1:0] load_data,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [WIDTH-1:0] pulses_sent
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_HIGH = 3'd2,
    S_LOW  = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t           state_q,       state_d;
  logic [WIDTH-1:0] remaining_q,   remaining_d;
  logic [WIDTH-1:0] pulses_sent_q, pulses_sent_d;
  logic [WIDTH-1:0] preload_q,     preload_d;
  logic [LEN_W-1:0] high_q,        high_d;
  logic [LEN_W-1:0] low_q,         low_d;
  logic [LEN_W-1:0] phase_q,       phase_d;
  logic             dir_q,         dir_d;
  logic             aborted_q,     aborted_d;

  // Phase counter start value: a programmed length of 0 behaves as 1 cycle,
  // and the counter runs down to 0 so it can never wrap.
  function automatic logic [LEN_W-1:0] phase_init(input logic [LEN_W-1:0] len);
    phase_init = (len == '0) ? '0 : len - LEN_W'(1);
  endfunction

  // Pulse tally sticks at all-ones instead of wrapping.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    sat_inc = (&v) ? v : v + WIDTH'(1);
  endfunction

  // Next-state and datapath update for the burst sequencer.
  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    pulses_sent_d = pulses_sent_q;
    preload_d     = preload_q;
    high_d        = high_q;
    low_d         = low_q;
    phase_d       = phase_q;
    dir_d         = dir_q;
    aborted_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // start wins over a simultaneous abort; abort alone is a no-op here
        if (start) begin
          remaining_d   = burst_len;
          pulses_sent_d = '0;
          preload_d     = preload_val;
          high_d        = high_len;
          low_d         = low_len;
          dir_d         = dir;
          if (preload_en) begin
            state_d = S_LOAD;
          end else if (burst_len != '0) begin
            state_d = S_HIGH;
            phase_d = phase_init(high_len);
          end else begin
            state_d = S_FIN;
          end
        end
      end

      S_LOAD: begin
        if (abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (remaining_q != '0) begin
          state_d = S_HIGH;
          phase_d = phase_init(high_q);
        end else begin
          state_d = S_FIN;
        end
      end

      S_HIGH: begin
        // an abort here cuts the pulse short, so it is not counted
        if (abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (phase_q == '0) begin
          remaining_d   = remaining_q - WIDTH'(1);
          pulses_sent_d = sat_inc(pulses_sent_q);
          state_d       = S_LOW;
          phase_d       = phase_init(low_q);
        end else begin
          phase_d = phase_q - LEN_W'(1);
        end
      end

      S_LOW: begin
        if (abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (phase_q == '0) begin
          if (remaining_q != '0) begin
            state_d = S_HIGH;
            phase_d = phase_init(high_q);
          end else begin
            state_d = S_FIN;
          end
        end else begin
          phase_d = phase_q - LEN_W'(1);
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and latched-field registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      remaining_q   <= '0;
      pulses_sent_q <= '0;
      preload_q     <= '0;
      high_q        <= '0;
      low_q         <= '0;
      phase_q       <= '0;
      dir_q         <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      pulses_sent_q <= pulses_sent_d;
      preload_q     <= preload_d;
      high_q        <= high_d;
      low_q         <= low_d;
      phase_q       <= phase_d;
      dir_q         <= dir_d;
      aborted_q     <= aborted_d;
    end
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    pulse_out   = (state_q == S_HIGH);
    enable      = (state_q == S_HIGH) || (state_q == S_LOW);
    load        = (state_q == S_LOAD);
    load_data   = (state_q == S_LOAD) ? preload_q : '0;
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_FIN);
    aborted     = aborted_q;
    up_down     = dir_q;
    pulses_sent = pulses_sent_q;
  end

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Directed bench for pulse_burst_gen: basic burst, preload, zero length,
// abort, start-while-busy, abort/start interplay and async reset mid-burst.
module tb_pulse_burst_gen;

  localparam int WIDTH = 8;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] burst_len;
  logic [LEN_W-1:0] high_len;
  logic [LEN_W-1:0] low_len;
  logic             dir;
  logic             preload_en;
  logic [WIDTH-1:0] preload_val;
  logic             pulse_out;
  logic             enable;
  logic             up_down;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [WIDTH-1:0] pulses_sent;

  int checks = 0;
  int errors = 0;

  pulse_burst_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .burst_len(burst_len), .high_len(high_len), .low_len(low_len),
    .dir(dir), .preload_en(preload_en), .preload_val(preload_val),
    .pulse_out(pulse_out), .enable(enable), .up_down(up_down),
    .load(load), .load_data(load_data), .busy(busy), .done(done),
    .aborted(aborted), .pulses_sent(pulses_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request, let edge 0 sample it; returns inside cycle 1.
  task automatic start_burst(input logic [WIDTH-1:0] bl, input logic [LEN_W-1:0] hl,
                             input logic [LEN_W-1:0] ll, input logic d,
                             input logic pe, input logic [WIDTH-1:0] pv);
    burst_len   = bl;
    high_len    = hl;
    low_len     = ll;
    dir         = d;
    preload_en  = pe;
    preload_val = pv;
    start       = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
  endtask

  logic [11:0] pulse_exp;
  logic [11:0] done_exp;
  logic [11:0] busy_exp;
  logic [11:0] en_exp;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    burst_len = '0; high_len = '0; low_len = '0;
    dir = 1'b0; preload_en = 1'b0; preload_val = '0;

    // reset state
    #2;
    chk("rst_pulse", pulse_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_enable", enable, 0);
    chk("rst_load", load, 0);
    chk("rst_sent", pulses_sent, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    chk("idle_busy", busy, 0);

    // basic burst: 3 pulses, high 2, low 1, up
    pulse_exp = 12'h1B6;
    done_exp  = 12'h400;
    busy_exp  = 12'h7FE;
    en_exp    = 12'h3FE;
    start_burst(8'd3, 4'd2, 4'd1, 1'b1, 1'b0, 8'h00);
    for (int c = 1; c <= 11; c++) begin
      chk($sformatf("basic_pulse_c%0d", c), pulse_out, pulse_exp[c]);
      chk($sformatf("basic_done_c%0d", c), done, done_exp[c]);
      chk($sformatf("basic_busy_c%0d", c), busy, busy_exp[c]);
      chk($sformatf("basic_en_c%0d", c), enable, en_exp[c]);
      chk($sformatf("basic_updown_c%0d", c), up_down, 1);
      if (c < 11) step();
    end
    chk("basic_sent", pulses_sent, 3);
    chk("basic_aborted", aborted, 0);

    // preload then a single 1-cycle pulse, down
    start_burst(8'd1, 4'd0, 4'd0, 1'b0, 1'b1, 8'hA5);
    chk("pre_load_c1", load, 1);
    chk("pre_data_c1", load_data, 8'hA5);
    chk("pre_pulse_c1", pulse_out, 0);
    chk("pre_updown_c1", up_down, 0);
    step();
    chk("pre_load_c2", load, 0);
    chk("pre_pulse_c2", pulse_out, 1);
    step();
    chk("pre_pulse_c3", pulse_out, 0);
    chk("pre_en_c3", enable, 1);
    chk("pre_done_c3", done, 0);
    step();
    chk("pre_done_c4", done, 1);
    step();
    chk("pre_busy_c5", busy, 0);
    chk("pre_sent", pulses_sent, 1);
    chk("pre_updown_hold", up_down, 0);

    // zero-length burst; abort during FIN has no effect
    start_burst(8'd0, 4'd3, 4'd3, 1'b1, 1'b0, 8'h00);
    abort = 1'b1;
    chk("zero_done_c1", done, 1);
    chk("zero_pulse_c1", pulse_out, 0);
    chk("zero_sent_c1", pulses_sent, 0);
    step();
    abort = 1'b0;
    chk("zero_busy_c2", busy, 0);
    chk("zero_aborted_c2", aborted, 0);

    // abort in the 3rd HIGH cycle (cycle 5)
    start_burst(8'd10, 4'd1, 4'd1, 1'b1, 1'b0, 8'h00);
    step(); step(); step(); step();
    chk("abt_pulse_c5", pulse_out, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abt_pulse_c6", pulse_out, 0);
    chk("abt_en_c6", enable, 0);
    chk("abt_aborted_c6", aborted, 1);
    chk("abt_done_c6", done, 0);
    chk("abt_busy_c6", busy, 0);
    chk("abt_sent_c6", pulses_sent, 2);
    step();
    chk("abt_aborted_c7", aborted, 0);
    chk("abt_done_c7", done, 0);

    // new start accepted, with abort asserted alongside start (start wins)
    abort = 1'b1;
    start_burst(8'd1, 4'd1, 4'd1, 1'b1, 1'b0, 8'h00);
    chk("restart_pulse_c1", pulse_out, 1);
    chk("restart_sent_c1", pulses_sent, 0);
    chk("restart_aborted_c1", aborted, 0);
    step();
    chk("restart_pulse_c2", pulse_out, 0);
    step();
    chk("restart_done_c3", done, 1);
    chk("restart_sent_c3", pulses_sent, 1);
    step();

    // start while busy is ignored
    start_burst(8'd2, 4'd1, 4'd1, 1'b1, 1'b0, 8'h00);
    step();
    burst_len = 8'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_start_pulse_c3", pulse_out, 1);
    step();
    chk("busy_start_pulse_c4", pulse_out, 0);
    step();
    chk("busy_start_done_c5", done, 1);
    step();
    chk("busy_start_busy_c6", busy, 0);
    chk("busy_start_sent", pulses_sent, 2);

    // async reset in the middle of a LOW phase
    start_burst(8'd3, 4'd1, 4'd3, 1'b1, 1'b0, 8'h00);
    step();
    chk("arst_pre_en", enable, 1);
    chk("arst_pre_pulse", pulse_out, 0);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_enable", enable, 0);
    chk("arst_updown", up_down, 0);
    chk("arst_sent", pulses_sent, 0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("arst_done_%0d", c), done, 0);
      chk($sformatf("arst_aborted_%0d", c), aborted, 0);
      chk($sformatf("arst_busy_%0d", c), busy, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
